// File: rtl/pwm_multi_if.sv
// Control and status bundle for pwm_multi: staging inputs toward the block,
// PWM outputs and status back to the controller.
interface pwm_multi_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  logic            en;
  logic            load;
  logic [W-1:0]    period_in;
  logic [CH*W-1:0] duty_in;
  logic            mode_in;
  logic            sweep_in;
  logic [CH-1:0]   dout;
  logic            cyc_start;
  logic            busy;

  modport master (
    output en, load, period_in, duty_in, mode_in, sweep_in,
    input  dout, cyc_start, busy
  );

  modport slave (
    input  en, load, period_in, duty_in, mode_in, sweep_in,
    output dout, cyc_start, busy
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter, double-buffered period/duty/mode,
// edge- or center-aligned counting and an optional per-period duty sweep.
module pwm_multi #(
  parameter int CH         = 4,
  parameter int W          = 8,
  parameter int DEF_PERIOD = 100,
  parameter int STEP       = 5
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);

  logic [W-1:0]  r_cnt;
  logic          r_dir;
  logic [W-1:0]  r_per;
  logic [W-1:0]  r_duty [CH];
  logic          r_mode;
  logic          r_sweep;
  logic [W-1:0]  r_stg_per;
  logic [W-1:0]  r_stg_duty [CH];
  logic          r_stg_mode;
  logic          r_stg_sweep;
  logic          r_busy;
  logic          r_cyc;
  logic [CH-1:0] r_dout;

  logic          w_bound;
  logic          w_apply;
  logic [W-1:0]  w_per;
  logic          w_mode;
  logic          w_sweep;
  logic          w_degen;
  logic          w_last;
  logic [W-1:0]  w_duty [CH];
  logic [CH-1:0] w_dout_nxt;
  logic [W-1:0]  w_cnt_nxt;
  logic          w_dir_nxt;

  // Sweep step in W+1 bits so the wrap test against the period cannot overflow.
  function automatic logic [W-1:0] sweep_step(input logic [W-1:0] d,
                                              input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, d} + (W+1)'(STEP);
    return (s > {1'b0, p}) ? '0 : s[W-1:0];
  endfunction

  // Values in force for this cycle: staged values take over at a boundary, or at once while disabled.
  always_comb begin
    w_bound = bus.en && (r_cnt == '0);
    w_apply = r_busy && (w_bound || !bus.en);
    w_per   = w_apply ? r_stg_per   : r_per;
    w_mode  = w_apply ? r_stg_mode  : r_mode;
    w_sweep = w_apply ? r_stg_sweep : r_sweep;
    w_degen = (w_per < W'(2));
    w_last  = (r_cnt >= w_per - W'(1));
    for (int i = 0; i < CH; i++) begin
      if (w_apply)
        w_duty[i] = r_stg_duty[i];
      else if (w_bound && r_sweep)
        w_duty[i] = sweep_step(r_duty[i], r_per);
      else
        w_duty[i] = r_duty[i];
      w_dout_nxt[i] = bus.en && !w_degen && (r_cnt < w_duty[i]);
    end
  end

  // Counter: r_dir=1 only on the falling half of a center-aligned period, so it is always up at cnt==0.
  always_comb begin
    w_cnt_nxt = '0;
    w_dir_nxt = 1'b0;
    if (bus.en && !w_degen) begin
      if (!w_mode) begin
        w_cnt_nxt = w_last ? '0 : r_cnt + W'(1);
      end else if (!r_dir && !w_last) begin
        w_cnt_nxt = r_cnt + W'(1);
      end else begin
        w_cnt_nxt = r_cnt - W'(1);
        w_dir_nxt = (r_cnt != W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_dout  <= '0;
      r_cyc   <= 1'b0;
      r_busy  <= 1'b0;
      r_per   <= W'(DEF_PERIOD);
      r_mode  <= 1'b0;
      r_sweep <= 1'b0;
      for (int i = 0; i < CH; i++) r_duty[i] <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_dout  <= w_dout_nxt;
      r_cyc   <= w_bound;
      r_busy  <= bus.load || (r_busy && !w_apply);
      r_per   <= w_per;
      r_mode  <= w_mode;
      r_sweep <= w_sweep;
      for (int i = 0; i < CH; i++) r_duty[i] <= w_duty[i];
    end
  end

  // Staging holds data only; r_busy says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (bus.load) begin
      r_stg_per   <= bus.period_in;
      r_stg_mode  <= bus.mode_in;
      r_stg_sweep <= bus.sweep_in;
      for (int i = 0; i < CH; i++) r_stg_duty[i] <= bus.duty_in[i*W +: W];
    end
  end

  assign bus.dout      = r_dout;
  assign bus.cyc_start = r_cyc;
  assign bus.busy      = r_busy;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator that supersedes the single-channel fixed-period block. All channels share one period counter. Each channel has its own duty value. Period, duty and mode are programmable and double-buffered, so updates only take effect at a period boundary. An optional auto-sweep mode steps every duty by a fixed amount each period, for LED-fade and motor-ramp use.

Parameters:
CH, 4, number of PWM channels
W, 8, width of the counter, period and duty values
DEF_PERIOD, 100, active period after reset (must be < 2^W)
STEP, 5, sweep increment per period

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  run enable
load  input  1  one-cycle strobe; capture period_in, duty_in, mode_in, sweep_in into the staging registers
period_in  input  W  period P, in counts
duty_in  input  CH*W  channel i duty = duty_in[i*W +: W]
mode_in  input  1  0 = edge-aligned, 1 = center-aligned
sweep_in  input  1  1 = auto-sweep duties
dout  output  CH  PWM outputs, registered
cyc_start  output  1  one-cycle pulse at the start of each period, registered
busy  output  1  staging registers hold an unapplied load

Behaviour:
- Reset (rst=1 at a clk edge) is synchronous, overrides everything, and may occur mid-period. It sets:
  - cnt=0, dir=up, dout=0, cyc_start=0, busy=0
  - active P=DEF_PERIOD, all active duties 0, mode 0, sweep 0
- Counter, edge mode: cnt runs 0,1,…,P-1, then returns to 0. Period length is P cycles.
- Counter, center mode: cnt runs 0→P-1 up, then P-2→1 down, then 0. Period length is 2(P-1) cycles.
- Boundary cycle: a cycle in which cnt==0 while en=1.
- Output compare: each enabled cycle, dout[i] <= (cnt < D[i]), where D[i] is channel i's active duty.
  - One cycle of latency from cnt to dout.
  - D=0 gives constant 0.
  - D>=P (edge) gives constant 1.
  - D>=P (center) gives constant 1.
- Degenerate period: P<2 forces cnt=0 and dout=0. Boundary events still occur every cycle.
- cyc_start <= 1 in the cycle after a boundary cycle, otherwise 0.
- Load:
  - load=1 writes the staging registers and sets busy=1.
  - A second load before the boundary overwrites the staging registers; last write wins.
- Apply at boundary:
  - If busy=1 at a boundary cycle, the staged P, duties, mode and sweep become active for the period that begins there.
  - busy clears on the next edge.
  - A load asserted in the boundary cycle itself is not applied then; it waits for the following boundary.
- Sweep, with active sweep=1 and no pending load at the boundary:
  - Each D[i] <= D[i]+STEP, computed with W+1-bit arithmetic.
  - If the result exceeds P, D[i] <= 0.
  - A pending load has priority over the sweep step.
- Mode change applied at a boundary: cnt restarts at 0 with dir=up.
- en=0:
  - cnt is held at 0 with dir=up, and dout=0.
  - Any pending staging is applied immediately; busy clears.
  - No cyc_start and no sweep step.
  - On en rising, the first enabled cycle is a boundary cycle with cnt=0.
- Width rules:
  - All compares are unsigned at W bits.
  - cnt never exceeds P-1.
  - No overflow is possible for P<=2^W-1.

Test Plan:
1. Edge duty check. Setup: CH=4, W=8; load P=10, duties {0,3,10,15}, mode 0; en=1. Required per 10-cycle window:
   - dout[0] always 0
   - dout[1] high 3 cycles, then low 7
   - dout[2] and dout[3] always 1
   - cyc_start pulses every 10 cycles
2. Center-aligned. Load P=5, mode 1, D0=2. Required:
   - cnt sequence 0,1,2,3,4,3,2,1 repeats (8 cycles)
   - dout[0] high 3 of every 8 cycles, on cnt=0,1,1
3. Sweep. Load P=20, D=0, sweep=1. Required: on successive periods, D = 0,5,10,15,20, then 0. dout high count per period matches D each period.
4. Double buffering. In edge mode with P=10, D1=3, pulse load with D1=7 at cnt=4. Required:
   - The current period still shows 3 high cycles.
   - The next period shows 7.
   - busy is high from load until one cycle after the boundary.
   - A load in the boundary cycle applies one period later.
5. Enable and degenerate period.
   - Deassert en mid-period: required dout=0 and cnt=0.
   - Reassert en: required cyc_start one cycle later.
   - Load P=1: required dout stays 0.
6. Reset mid-operation. Assert rst at cnt=6 with sweep active and load pending. Required next cycle:
   - dout=0, busy=0, cnt=0
   - after release, P=100 and D=0
